// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ready imem reads and
// feeds IF/ID through a one-entry skid buffer with redirect handling.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   output logic [31:0] if_inst_o,
   output logic [31:0] if_pc4_o
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      FULL,
      DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;

   logic [31:0] tgt;
   logic [31:0] pc_inc;
   logic        accept;

   assign tgt    = {redirect_pc_i[31:2], 2'b00};
   assign pc_inc = pc_q + 32'd4;
   assign accept = valid_q & ~stall_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_d     = redir_q;
      skid_inst_d = skid_inst_q;
      skid_pc4_d  = skid_pc4_q;
      inst_d      = inst_q;
      pc4_d       = pc4_q;
      imem_req_o  = 1'b0;
      // Accepted or flushed output empties unless refilled below
      valid_d     = valid_q & ~accept & ~redirect_i;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_i) pc_d = tgt;
         end
         FETCH: begin
            imem_req_o = 1'b1;
            if (redirect_i) begin
               if (imem_ready_i) begin
                  pc_d = tgt;
               end else begin
                  redir_d = tgt;
                  state_d = DRAIN;
               end
            end else if (imem_ready_i) begin
               pc_d = pc_inc;
               if (!valid_q || !stall_i) begin
                  valid_d = 1'b1;
                  inst_d  = imem_rdata_i;
                  pc4_d   = pc_inc;
               end else begin
                  skid_inst_d = imem_rdata_i;
                  skid_pc4_d  = pc_inc;
                  state_d     = FULL;
               end
            end
         end
         FULL: begin
            if (redirect_i) begin
               pc_d    = tgt;
               state_d = FETCH;
            end else if (!stall_i) begin
               valid_d = 1'b1;
               inst_d  = skid_inst_q;
               pc4_d   = skid_pc4_q;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            imem_req_o = 1'b1;
            if (imem_ready_i) begin
               pc_d    = redirect_i ? tgt : redir_q;
               state_d = FETCH;
            end else if (redirect_i) begin
               redir_d = tgt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         redir_q     <= 32'h0;
         skid_inst_q <= 32'h0;
         skid_pc4_q  <= 32'h0;
         valid_q     <= 1'b0;
         inst_q      <= 32'h0;
         pc4_q       <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_q     <= redir_d;
         skid_inst_q <= skid_inst_d;
         skid_pc4_q  <= skid_pc4_d;
         valid_q     <= valid_d;
         inst_q      <= inst_d;
         pc4_q       <= pc4_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign if_valid_o  = valid_q;
   assign if_inst_o   = inst_q;
   assign if_pc4_o    = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus
// hand-written reset, wraparound and idle-redirect sequences.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_inst_o;
   logic [31:0] if_pc4_o;

   logic        rst2_n;
   logic        req2;
   logic [31:0] addr2;
   logic [31:0] rdata2;
   logic        valid2;
   logic [31:0] inst2;
   logic [31:0] pc4_2;

   int n_cmp;
   int n_bad;
   int step;

   // Memory returns a recognisable word tagged with the low address bits
   assign imem_rdata_i = imem_ready_i ? {16'hC0DE, imem_addr_o[15:0]}
                                      : 32'hDEAD_BEEF;
   assign rdata2       = {16'hC0DE, addr2[15:0]};

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ready_i  (imem_ready_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_inst_o     (if_inst_o),
      .if_pc4_o      (if_pc4_o)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk           (clk),
      .rst_n         (rst2_n),
      .stall_i       (1'b0),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'h0),
      .imem_req_o    (req2),
      .imem_addr_o   (addr2),
      .imem_ready_i  (1'b1),
      .imem_rdata_i  (rdata2),
      .if_valid_o    (valid2),
      .if_inst_o     (inst2),
      .if_pc4_o      (pc4_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc4;
   } vec_t;

   localparam int NV = 33;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h want %h", name, step, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic r,
                               input logic [31:0] p, input logic rd,
                               input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
      vec_t v;
      v.stall = s;  v.redir = r;  v.rpc = p;    v.ready = rd;
      v.ereq = eq;  v.eaddr = ea; v.evalid = ev; v.epc4 = ep;
      return v;
   endfunction

   initial begin
      logic [31:0] a;
      logic [31:0] ei;
      n_cmp = 0;
      n_bad = 0;
      step  = -1;

      // stall, redirect, target, ready | req, addr, valid, pc4
      tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
      tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h4);
      tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h8);
      tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'hC);
      tbl[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'h10);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h10);
      tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h10);
      tbl[8]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h10);
      tbl[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 32'h10);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b1, 32'h14);
      tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b1, 32'h18);
      tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b0, 32'h0);
      tbl[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b0, 32'h0);
      tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1C,  1'b1, 32'h1C);
      tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h1C,  1'b0, 32'h0);
      tbl[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b0, 32'h0);
      tbl[17] = mk(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h20,  1'b1, 32'h20);
      tbl[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20,  1'b0, 32'h0);
      tbl[19] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b0, 32'h0);
      tbl[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      tbl[21] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h204);
      tbl[22] = mk(1'b1, 1'b1, 32'h81,  1'b0, 1'b0, 32'h0,   1'b1, 32'h204);
      tbl[23] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h80,  1'b0, 32'h0);
      tbl[24] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80,  1'b0, 32'h0);
      tbl[25] = mk(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h84,  1'b1, 32'h84);
      tbl[26] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
      tbl[27] = mk(1'b0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
      tbl[28] = mk(1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
      tbl[29] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
      tbl[30] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
      tbl[31] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
      tbl[32] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h504, 1'b1, 32'h504);

      rst_n         = 1'b0;
      rst2_n        = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      imem_ready_i  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
      chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
      chk("rst_inst",  if_inst_o,           32'h0);
      chk("rst_pc4",   if_pc4_o,            32'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         step          = i;
         stall_i       = tbl[i].stall;
         redirect_i    = tbl[i].redir;
         redirect_pc_i = tbl[i].rpc;
         imem_ready_i  = tbl[i].ready;
         #1;
         chk("req",   {31'h0, imem_req_o}, {31'h0, tbl[i].ereq});
         chk("valid", {31'h0, if_valid_o}, {31'h0, tbl[i].evalid});
         if (tbl[i].ereq)
            chk("addr", imem_addr_o, tbl[i].eaddr);
         if (tbl[i].evalid) begin
            a  = tbl[i].epc4 - 32'd4;
            ei = {16'hC0DE, a[15:0]};
            chk("pc4",  if_pc4_o,  tbl[i].epc4);
            chk("inst", if_inst_o, ei);
         end
         if (i == 0)
            chk("wrap_idle_req", {31'h0, req2}, 32'h0);
         if (i == 1)
            chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
         if (i == 2) begin
            chk("wrap_valid", {31'h0, valid2}, 32'h1);
            chk("wrap_pc4",   pc4_2,           32'h0);
            chk("wrap_inst",  inst2,           32'hC0DE_FFFC);
            chk("wrap_addr1", addr2,           32'h0);
         end
         @(negedge clk);
      end

      // Reset while a request is outstanding and the output is live
      step         = 100;
      stall_i      = 1'b1;
      redirect_i   = 1'b0;
      imem_ready_i = 1'b0;
      #1;
      chk("pre_rst_req",   {31'h0, imem_req_o}, 32'h1);
      chk("pre_rst_valid", {31'h0, if_valid_o}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",   {31'h0, imem_req_o}, 32'h0);
      chk("mid_rst_valid", {31'h0, if_valid_o}, 32'h0);
      chk("mid_rst_pc4",   if_pc4_o,            32'h0);
      chk("mid_rst_inst",  if_inst_o,           32'h0);

      // Redirect taken while idle right after reset
      @(negedge clk);
      step          = 101;
      rst_n         = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h40;
      #1;
      chk("idle_req", {31'h0, imem_req_o}, 32'h0);
      @(negedge clk);
      step         = 102;
      redirect_i   = 1'b0;
      imem_ready_i = 1'b0;
      #1;
      chk("idle_redir_req",  {31'h0, imem_req_o}, 32'h1);
      chk("idle_redir_addr", imem_addr_o,         32'h40);
      @(negedge clk);
      step         = 103;
      imem_ready_i = 1'b1;
      #1;
      chk("hold_addr", imem_addr_o, 32'h40);
      @(negedge clk);
      step         = 104;
      imem_ready_i = 1'b0;
      #1;
      chk("idle_redir_valid", {31'h0, if_valid_o}, 32'h1);
      chk("idle_redir_pc4",   if_pc4_o,            32'h44);
      chk("idle_redir_inst",  if_inst_o,           32'hC0DE_0040);
      chk("next_addr",        imem_addr_o,         32'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
